// File: rtl/arbitro_rr.sv
// arbitro_rr: two-requester round-robin arbiter with a bounded hold before preemption
module arbitro_rr #(
  parameter int MAX_HOLD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
  localparam logic [3:0] MAX = 4'(MAX_HOLD);
  state_t     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt1_q;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (req0 && (!req1 || last_q)) ? GNT0 : req1 ? GNT1 : IDLE;
    else if (state_q == GNT0)
      state_d = (!req0 || (req1 && hold_cnt_q == MAX)) ? (req1 ? GNT1 : IDLE) : GNT0;
    else if (state_q == GNT1)
      state_d = (!req1 || (req0 && hold_cnt_q == MAX)) ? (req0 ? GNT0 : IDLE) : GNT1;
    else
      state_d = IDLE;
    hold_cnt_d = (state_d == IDLE) ? 4'd0 :
                 (state_d != state_q) ? 4'd1 :
                 (hold_cnt_q == MAX) ? hold_cnt_q : hold_cnt_q + 4'd1;
    last_d = (state_d == GNT0) ? 1'b0 : (state_d == GNT1) ? 1'b1 : last_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= 4'd0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      gnt0_q     <= state_d == GNT0;
      gnt1_q     <= state_d == GNT1;
    end
  end
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: directed vectors against hand-computed grant patterns
module tb_arbitro_rr;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic gnt0, gnt1;
  int total = 0;
  int bad = 0;
  arbitro_rr #(.MAX_HOLD(4)) dut (
    .clock(clock),
    .reset(reset),
    .req0(req0),
    .req1(req1),
    .gnt0(gnt0),
    .gnt1(gnt1)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // advance one edge, then compare {gnt1,gnt0} away from the edge
  task automatic cyc(input string tag, input logic [1:0] exp);
    @(posedge clock);
    #1;
    chk(tag, {2'b00, gnt1, gnt0}, {2'b00, exp});
  endtask
  initial begin
    #1;
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    cyc("rst_a", 2'b00);
    chk("rst_hold", dut.hold_cnt_q, 4'd0);
    cyc("rst_b", 2'b00);
    reset = 1'b1;
    cyc("rel_tie", 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    cyc("to_idle", 2'b00);
    req0 = 1'b1;
    cyc("pulse_1", 2'b01);
    cyc("pulse_2", 2'b01);
    req0 = 1'b0;
    cyc("pulse_end", 2'b00);
    cyc("pulse_idle", 2'b00);
    reset = 1'b0;
    cyc("rst2", 2'b00);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc($sformatf("rr_%0d", i), ((i / 4) % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("rr_hold_%0d", i), dut.hold_cnt_q, 4'((i % 4) + 1));
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc("rr_idle", 2'b00);
    req0 = 1'b1;
    cyc("drop_a", 2'b01);
    req1 = 1'b1;
    cyc("drop_b", 2'b01);
    req0 = 1'b0;
    cyc("drop_xfer", 2'b10);
    req1 = 1'b0;
    cyc("solo_pre", 2'b00);
    req1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("solo_%0d", i), 2'b10);
      chk($sformatf("solo_hold_%0d", i), dut.hold_cnt_q, (i < 3) ? 4'(i + 1) : 4'd4);
    end
    req0 = 1'b1; reset = 1'b0;
    cyc("mid_rst", 2'b00);
    chk("mid_rst_hold", dut.hold_cnt_q, 4'd0);
    reset = 1'b1;
    cyc("mid_rel", 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    cyc("last0_idle", 2'b00);
    req0 = 1'b1; req1 = 1'b1;
    cyc("last0_tie", 2'b10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
